secure_xfer_ctrl: RTL
=====================

Name: secure_xfer_ctrl

Overview:
- Sequencer for the secure memory→security→register datapath.
- Accepts block-transfer commands over a valid/ready handshake. Each command is a source memory address, a destination register address, a word count and an encrypt flag.
- Steps the memory address, waits the memory read latency, then strobes the register write of the secured word, once per word.
- Sits between the command source (host/DMA logic) and the secure datapath, replacing the direct address/encryption drive.

Parameters:
- ADDR_W, 10, width of memory and register addresses
- LEN_W, 8, width of the word-count field
- MEM_LAT, 1, cycles from mem_address change to valid secured data (≥1)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  command valid
- req_ready  out  1  controller can accept a command (IDLE only)
- req_mem_addr  in  ADDR_W  first source memory address
- req_reg_addr  in  ADDR_W  first destination register address
- req_len  in  LEN_W  words to transfer (0 allowed)
- req_encrypt  in  1  encryption_on value for the whole transfer
- abort  in  1  cancel the in-flight transfer
- mem_address  out  ADDR_W  to datapath memory address
- encryption_on  out  1  to datapath security stage
- reg_address  out  ADDR_W  to datapath register address
- reg_write_en  out  1  one-cycle register write strobe
- busy  out  1  transfer in progress
- done  out  1  one-cycle pulse, transfer completed
- aborted  out  1  one-cycle pulse, transfer cancelled

Behaviour:
- Reset values (rst high at a clk edge): state IDLE, all counters 0, mem_address=0, reg_address=0, encryption_on=0, reg_write_en=0, busy=0, done=0, aborted=0, req_ready=0 during the reset cycle, then 1.
- Handshake:
  - A command is accepted on a clk edge where req_valid && req_ready.
  - The command fields are latched at acceptance. Later input changes have no effect.
  - req_ready=1 only in IDLE and not in reset.
- FSM states and transitions:
  - IDLE: on accept with req_len=0 → DONE. On accept with req_len>0 → ISSUE; load address registers and the remaining count.
  - ISSUE: drive mem_address = current source address; load the latency timer with MEM_LAT-1; → WAIT.
  - WAIT: count the timer down. When it reads 0 → WRITE. MEM_LAT=1 means WAIT lasts one cycle.
  - WRITE: reg_write_en=1 for exactly this cycle, with reg_address = current destination address. Then increment both addresses and decrement the remaining count. If the remaining count is now 0 → DONE, else → ISSUE.
  - DONE: done=1 for one cycle → IDLE.
- Throughput: MEM_LAT+2 cycles per word. Command accept to first reg_write_en is MEM_LAT+1 cycles.
- busy=1 in ISSUE, WAIT, WRITE and DONE.
- encryption_on holds the latched req_encrypt from acceptance through DONE, and is 0 in IDLE.
- Address wrap-around: both addresses increment modulo 2^ADDR_W (0x3FF → 0x000). No error is raised.
- mem_address holds its last value outside ISSUE/WAIT/WRITE.
- abort:
  - Sampled in any non-IDLE state. The next state is IDLE and aborted=1 for one cycle.
  - If abort coincides with WRITE, that cycle's reg_write_en still asserts, since the write is already committed.
  - No done pulse is produced.
  - abort in IDLE is ignored.
- rst mid-transfer: immediate return to the reset values. No done or aborted pulse.
- req_len = 2^LEN_W-1 is legal.

Optional Feature:
- Macro SECURE_XFER_STATS_EN.
- When defined:
  - Adds output words_written [15:0]: increments on every reg_write_en and saturates at 0xFFFF.
  - Adds output xfer_count [15:0]: increments on every done pulse and saturates at 0xFFFF.
  - Both clear only on rst.
- When undefined: neither port nor counter exists, and all other behaviour is identical.

Decomposition:
- Shared package secure_pkg holds:
  - ADDR_W and DATA_W (32) constants
  - the xfer_state_t enum (IDLE, ISSUE, WAIT, WRITE, DONE)
  - a xfer_cmd_t struct (mem_addr, reg_addr, len, encrypt)
- Sub-module secure_lat_timer is natural: a loadable down-counter with a zero flag, parameterised by MEM_LAT. It is reused by later datapath controllers.

Test Plan:
- Reset, then cmd mem=0x010, reg=0x020, len=3, enc=1, MEM_LAT=1 → reg_write_en pulses at cycles 2, 5, 8 after accept, with reg_address 0x020/0x021/0x022 and mem_address 0x010/0x011/0x012; encryption_on=1 throughout; done pulses at cycle 9; req_ready=0 until done.
- len=0 → done one cycle after accept, no reg_write_en, busy high for exactly 1 cycle.
- Wrap: mem=0x3FE, reg=0x3FF, len=3 → mem_address sequence 0x3FE, 0x3FF, 0x000 and reg_address sequence 0x3FF, 0x000, 0x001.
- abort asserted in the WAIT of word 2 of 4 → exactly 1 write, aborted pulse, no done, back in IDLE with req_ready=1 the next cycle.
- rst asserted mid-WRITE of a 5-word transfer → all outputs at reset values the next cycle; a new command accepted afterwards runs cleanly.
- MEM_LAT=3 with SECURE_XFER_STATS_EN: two back-to-back 2-word commands → 5 cycles per word, words_written=4, xfer_count=2.

Source files
------------

// File: rtl/secure_pkg.sv
// Shared types and constants for the secure memory->security->register datapath.
// Used by secure_xfer_ctrl and later datapath controllers.
package secure_pkg;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 32;
  localparam int LEN_W  = 8;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    WRITE,
    DONE
  } xfer_state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] mem_addr;
    logic [ADDR_W-1:0] reg_addr;
    logic [LEN_W-1:0]  len;
    logic              encrypt;
  } xfer_cmd_t;

endpackage

// File: rtl/secure_lat_timer.sv
// Loadable down-counter with a zero flag; load value is MEM_LAT-1 so a
// WAIT phase that counts to zero spans exactly MEM_LAT cycles.
module secure_lat_timer #(
  parameter int MEM_LAT = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic i_load,
  input  logic i_dec,
  output logic o_zero
);

  localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(MEM_LAT - 1);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= LOAD_VAL;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - CNT_W'(1);
    end
  end

  assign o_zero = (r_count == '0);

endmodule

// File: rtl/secure_xfer_ctrl.sv
// Block-transfer sequencer: steps memory addresses, waits MEM_LAT, strobes register writes.
// Optional SECURE_XFER_STATS_EN adds saturating words_written / xfer_count outputs.
//
// state | meaning
// IDLE  | waiting for a command, req_ready high
// ISSUE | present current source address, arm latency timer
// WAIT  | memory read latency in progress
// WRITE | one-cycle register write strobe, advance addresses
// DONE  | one-cycle done pulse
module secure_xfer_ctrl
  import secure_pkg::xfer_state_t, secure_pkg::xfer_cmd_t,
         secure_pkg::IDLE, secure_pkg::ISSUE, secure_pkg::WAIT,
         secure_pkg::WRITE, secure_pkg::DONE;
#(
  parameter int ADDR_W  = secure_pkg::ADDR_W,
  parameter int LEN_W   = secure_pkg::LEN_W,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_mem_addr,
  input  logic [ADDR_W-1:0] req_reg_addr,
  input  logic [LEN_W-1:0]  req_len,
  input  logic              req_encrypt,
  input  logic              abort,
  output logic [ADDR_W-1:0] mem_address,
  output logic              encryption_on,
  output logic [ADDR_W-1:0] reg_address,
  output logic              reg_write_en,
  output logic              busy,
  output logic              done,
  output logic              aborted
`ifdef SECURE_XFER_STATS_EN
  ,
  output logic [15:0]       words_written,
  output logic [15:0]       xfer_count
`endif
);

  // The latched command reuses the shared struct, so widths must match the package.
  if ((ADDR_W != secure_pkg::ADDR_W) || (LEN_W != secure_pkg::LEN_W) || (MEM_LAT < 1))
  begin : g_bad_param
    $error("secure_xfer_ctrl: unsupported ADDR_W/LEN_W/MEM_LAT");
  end

  xfer_state_t       r_state;
  xfer_state_t       w_state_nxt;
  xfer_cmd_t         r_cmd;
  logic [ADDR_W-1:0] r_mem_address;
  logic              r_aborted;
  logic              w_accept;
  logic              w_abort_hit;
  logic              w_tmr_zero;

  assign w_accept    = req_valid && req_ready;
  assign w_abort_hit = abort && (r_state != IDLE);

  secure_lat_timer #(
    .MEM_LAT (MEM_LAT)
  ) u_lat_timer (
    .clk    (clk),
    .rst    (rst),
    .i_load (r_state == ISSUE),
    .i_dec  (r_state == WAIT),
    .o_zero (w_tmr_zero)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_state_nxt = (req_len == '0) ? DONE : ISSUE;
        end
      end
      ISSUE: w_state_nxt = WAIT;
      WAIT: begin
        if (w_tmr_zero) begin
          w_state_nxt = WRITE;
        end
      end
      WRITE: w_state_nxt = (r_cmd.len == LEN_W'(1)) ? DONE : ISSUE;
      DONE:  w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
    if (w_abort_hit) begin
      w_state_nxt = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= IDLE;
      r_cmd         <= '0;
      r_mem_address <= '0;
      r_aborted     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_aborted <= w_abort_hit;
      if (w_accept) begin
        r_cmd.encrypt <= req_encrypt;
        if (req_len != '0) begin
          r_cmd.mem_addr <= req_mem_addr;
          r_cmd.reg_addr <= req_reg_addr;
          r_cmd.len      <= req_len;
        end
      end
      if (r_state == WRITE) begin
        r_cmd.mem_addr <= r_cmd.mem_addr + ADDR_W'(1);
        r_cmd.reg_addr <= r_cmd.reg_addr + ADDR_W'(1);
        r_cmd.len      <= r_cmd.len - LEN_W'(1);
      end
      // mem_address only moves when a word is issued, so it holds through DONE/IDLE/abort.
      if (w_state_nxt == ISSUE) begin
        r_mem_address <= (r_state == IDLE) ? req_mem_addr : (r_cmd.mem_addr + ADDR_W'(1));
      end
    end
  end

  assign req_ready     = (r_state == IDLE) && !rst;
  assign mem_address   = r_mem_address;
  assign reg_address   = r_cmd.reg_addr;
  assign encryption_on = (r_state != IDLE) && r_cmd.encrypt;
  assign reg_write_en  = (r_state == WRITE);
  assign busy          = (r_state != IDLE);
  assign done          = (r_state == DONE);
  assign aborted       = r_aborted;

`ifdef SECURE_XFER_STATS_EN
  logic [15:0] r_words_written;
  logic [15:0] r_xfer_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_words_written <= '0;
      r_xfer_count    <= '0;
    end else begin
      if (reg_write_en && (r_words_written != 16'hFFFF)) begin
        r_words_written <= r_words_written + 16'd1;
      end
      if (done && (r_xfer_count != 16'hFFFF)) begin
        r_xfer_count <= r_xfer_count + 16'd1;
      end
    end
  end

  assign words_written = r_words_written;
  assign xfer_count    = r_xfer_count;
`endif

endmodule
